// File: rtl/cache_requester.sv
// Single-outstanding sequencer between an upstream requester, the CLOCK-sweep cache
// and a write-through backing memory. Handles read hit/miss-fill and write-through writes.
module cache_requester #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LINE_WIDTH = 32,
    parameter int unsigned WAIT_MAX   = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [LINE_WIDTH-1:0] resp_rdata,
    output logic                  resp_hit,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [LINE_WIDTH-1:0] cache_val,
    output logic                  cache_read,
    output logic                  cache_write,
    input  logic                  cache_hit,
    input  logic [LINE_WIDTH-1:0] cache_out_val,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [LINE_WIDTH-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_CHECK,
        S_MEM_RD,
        S_FILL,
        S_WR_CACHE,
        S_MEM_WR,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_data;
    logic                  r_write;
    logic [CNT_W-1:0]      r_wait;
    logic                  r_wr_hit;

    logic                  r_req_ready;
    logic                  r_cache_read;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic                  r_resp_valid;
    logic [LINE_WIDTH-1:0] r_resp_rdata;
    logic                  r_resp_hit;
    logic                  r_resp_err;

    logic                  w_in_wr;
    logic                  w_hit_seen;
    logic                  w_timeout;
    logic                  w_cache_write;
    logic [LINE_WIDTH-1:0] w_resp_rdata;
    logic                  w_resp_hit;
    logic                  w_resp_err;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, shared write sequencer and response payload
    always_comb begin
        w_next        = r_state;
        w_in_wr       = 1'b0;
        w_hit_seen    = 1'b0;
        w_timeout     = 1'b0;
        w_cache_write = 1'b0;
        w_resp_rdata  = '0;
        w_resp_hit    = 1'b0;
        w_resp_err    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = req_write ? S_WR_CACHE : S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                w_next = S_RD_CHECK;
            end
            S_RD_CHECK: begin
                if (cache_hit) begin
                    w_next       = S_RESP;
                    w_resp_rdata = cache_out_val;
                    w_resp_hit   = 1'b1;
                end else begin
                    w_next = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (mem_ack) begin
                    w_next = S_FILL;
                end
            end
            S_FILL, S_WR_CACHE: begin
                // cache_hit in cycle 0 still reflects the previous operation
                w_in_wr       = 1'b1;
                w_hit_seen    = (r_wait != '0) && cache_hit;
                w_timeout     = !w_hit_seen && (r_wait == CNT_W'(WAIT_MAX));
                w_cache_write = !w_hit_seen && !w_timeout;
                if (w_timeout) begin
                    w_next     = S_RESP;
                    w_resp_err = 1'b1;
                end else if (w_hit_seen) begin
                    if (r_state == S_FILL) begin
                        w_next       = S_RESP;
                        w_resp_rdata = r_data;
                    end else begin
                        w_next = S_MEM_WR;
                    end
                end
            end
            S_MEM_WR: begin
                if (mem_ack) begin
                    w_next     = S_RESP;
                    w_resp_hit = r_wr_hit;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latch, fill value, wait counter and write-hit record
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr   <= '0;
            r_data   <= '0;
            r_write  <= 1'b0;
            r_wait   <= '0;
            r_wr_hit <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && req_valid) begin
                r_addr   <= req_addr;
                r_data   <= req_wdata;
                r_write  <= req_write;
                r_wr_hit <= 1'b0;
            end else if ((r_state == S_MEM_RD) && mem_ack) begin
                r_data <= mem_rdata;
            end

            if ((r_state == S_WR_CACHE) && (r_wait == CNT_W'(1))) begin
                r_wr_hit <= cache_hit;
            end

            if (w_in_wr && (w_next == r_state)) begin
                r_wait <= r_wait + CNT_W'(1);
            end else begin
                r_wait <= '0;
            end
        end
    end

    // Outputs registered from the next-state decode
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_req_ready  <= 1'b0;
            r_cache_read <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_hit   <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_req_ready  <= (w_next == S_IDLE);
            r_cache_read <= (w_next == S_RD_ISSUE);
            r_mem_req    <= (w_next == S_MEM_RD) || (w_next == S_MEM_WR);
            r_mem_we     <= (w_next == S_MEM_WR) && r_write;
            r_resp_valid <= (w_next == S_RESP);
            r_resp_rdata <= w_resp_rdata;
            r_resp_hit   <= w_resp_hit;
            r_resp_err   <= w_resp_err;
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_hit    = r_resp_hit;
    assign resp_err    = r_resp_err;
    assign cache_addr  = r_addr;
    assign cache_val   = r_data;
    assign cache_read  = r_cache_read;
    // Drops in the same cycle the hit arrives so the cache sees no extra write
    assign cache_write = w_cache_write;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_data;

endmodule

// File: tb/tb_cache_requester.sv
// Randomized bench for cache_requester: behavioural 2-way CLOCK cache, latency-programmable
// backing memory and a reference memory image that predicts every response.
module tb_cache_requester;

    localparam int AW = 8;
    localparam int LW = 32;
    localparam int WM = 16;
    localparam int K  = 2;
    localparam int HW = $clog2(K);

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_wdata;
    logic          req_ready;
    logic          resp_valid;
    logic [LW-1:0] resp_rdata;
    logic          resp_hit;
    logic          resp_err;
    logic [AW-1:0] cache_addr;
    logic [LW-1:0] cache_val;
    logic          cache_read;
    logic          cache_write;
    logic          cache_hit;
    logic [LW-1:0] cache_out_val;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_ack;
    logic [LW-1:0] mem_rdata;

    cache_requester #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .WAIT_MAX(WM)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit), .resp_err(resp_err),
        .cache_addr(cache_addr), .cache_val(cache_val), .cache_read(cache_read), .cache_write(cache_write),
        .cache_hit(cache_hit), .cache_out_val(cache_out_val),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] init_word(input logic [AW-1:0] a);
        if (a == 8'h20) return 32'h1234_5678;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    // Backing memory: ack after mem_lat extra cycles (0 = same cycle as mem_req)
    logic [LW-1:0] bmem [256];
    bit            bwritten [256];
    int            mem_lat = 0;
    int            m_cnt;

    assign mem_ack   = mem_req && (m_cnt == mem_lat);
    assign mem_rdata = bwritten[mem_addr] ? bmem[mem_addr] : init_word(mem_addr);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) m_cnt <= 0;
        else if (mem_req && !mem_ack) m_cnt <= m_cnt + 1;
        else m_cnt <= 0;
    end

    always @(posedge clock) begin
        if (mem_ack && mem_we) begin
            bmem[mem_addr]     <= mem_wdata;
            bwritten[mem_addr] <= 1'b1;
        end
    end

    function automatic logic [LW-1:0] mem_now(input logic [AW-1:0] a);
        return bwritten[a] ? bmem[a] : init_word(a);
    endfunction

    // Cache: K-way fully associative, CLOCK replacement, outputs registered
    logic [AW-1:0] c_tag  [K];
    logic [LW-1:0] c_data [K];
    bit            c_valid [K];
    bit            c_ref   [K];
    logic [HW-1:0] c_hand = '0;
    bit            c_sweep = 1'b0;
    bit            force_miss = 1'b0;
    logic          c_found;
    logic [HW-1:0] c_idx;

    always_comb begin
        c_found = 1'b0;
        c_idx   = '0;
        for (int i = 0; i < K; i++) begin
            if (!c_found && c_valid[i] && (c_tag[i] == cache_addr)) begin
                c_found = 1'b1;
                c_idx   = HW'(i);
            end
        end
    end

    always @(posedge clock) begin
        cache_hit <= 1'b0;
        if (!force_miss) begin
            if (cache_read) begin
                if (c_found) begin
                    cache_hit      <= 1'b1;
                    cache_out_val  <= c_data[c_idx];
                    c_ref[c_idx]   <= 1'b1;
                end
            end else if (cache_write) begin
                if (!c_sweep) begin
                    if (c_found) begin
                        c_data[c_idx] <= cache_val;
                        c_ref[c_idx]  <= 1'b1;
                        cache_hit     <= 1'b1;
                    end else begin
                        c_sweep <= 1'b1;
                    end
                end else begin
                    if (!c_valid[c_hand] || !c_ref[c_hand]) begin
                        c_valid[c_hand] <= 1'b1;
                        c_tag[c_hand]   <= cache_addr;
                        c_data[c_hand]  <= cache_val;
                        c_ref[c_hand]   <= 1'b1;
                        c_sweep         <= 1'b0;
                        cache_hit       <= 1'b1;
                    end else begin
                        c_ref[c_hand] <= 1'b0;
                    end
                    c_hand <= c_hand + 1'b1;
                end
            end
        end
    end

    function automatic bit cache_has(input logic [AW-1:0] a);
        for (int i = 0; i < K; i++) begin
            if (c_valid[i] && (c_tag[i] == a)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Reference view of memory contents as the upstream requester sees it
    logic [LW-1:0] ref_mem [256];

    task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d,
                          output int lat, output logic [LW-1:0] rd, output bit hit, output bit err,
                          output int n_mr, output int n_cw, output int first_mr, output int n_bad);
        int w;
        w = 0;
        while (!req_ready && (w < 40)) begin
            @(negedge clock);
            w++;
        end
        chk("ready_before_req", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        lat = -1; rd = '0; hit = 1'b0; err = 1'b0;
        n_mr = 0; n_cw = 0; first_mr = -1; n_bad = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clock);
            if (mem_req) begin
                n_mr++;
                if (first_mr < 0) first_mr = k;
                if (mem_we != wr) n_bad++;
                if (wr && (mem_wdata != d)) n_bad++;
                if (mem_addr != a) n_bad++;
            end
            if (cache_write) n_cw++;
            if (resp_valid) begin
                lat = k;
                rd  = resp_rdata;
                hit = resp_hit;
                err = resp_err;
                break;
            end
        end
        chk("resp_seen", 64'(lat >= 0), 64'(1));
        @(negedge clock);
        chk("resp_one_cycle", 64'(resp_valid), 64'(0));
        chk("ready_after_resp", 64'(req_ready), 64'(1));
    endtask

    task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
        bit            exp_hit;
        int            lat, n_mr, n_cw, first_mr, n_bad;
        logic [LW-1:0] rd;
        bit            hit, err;
        exp_hit = cache_has(a);
        do_req(wr, a, d, lat, rd, hit, err, n_mr, n_cw, first_mr, n_bad);
        chk("resp_err", 64'(err), 64'(0));
        chk("resp_hit", 64'(hit), 64'(exp_hit));
        chk("mem_fields", 64'(n_bad), 64'(0));
        chk("resident", 64'(cache_has(a)), 64'(1));
        if (wr) begin
            ref_mem[a] = d;
            chk("wr_rdata_zero", 64'(rd), 64'(0));
            chk("wr_through", 64'(mem_now(a)), 64'(d));
            chk("wr_memreq_cycles", 64'(n_mr), 64'(mem_lat + 1));
            if (exp_hit) begin
                chk("wr_hit_lat", 64'(lat), 64'(4 + mem_lat));
                chk("wr_hit_cwr_cycles", 64'(n_cw), 64'(1));
            end
        end else begin
            chk("rd_data", 64'(rd), 64'(ref_mem[a]));
            if (exp_hit) begin
                chk("rd_hit_lat", 64'(lat), 64'(3));
                chk("rd_hit_no_mem", 64'(n_mr), 64'(0));
            end else begin
                chk("rd_miss_memreq_cycles", 64'(n_mr), 64'(mem_lat + 1));
                chk("rd_miss_memreq_start", 64'(first_mr), 64'(3));
            end
        end
    endtask

    initial begin
        int w;
        int lat, n_mr, n_cw, first_mr, n_bad;
        logic [LW-1:0] rd;
        bit hit, err;
        logic [AW-1:0] addrs [6];

        addrs[0] = 8'h10; addrs[1] = 8'h20; addrs[2] = 8'h30;
        addrs[3] = 8'h40; addrs[4] = 8'h50; addrs[5] = 8'h60;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(AW'(i));

        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_cache_read", 64'(cache_read), 64'(0));
        chk("rst_cache_write", 64'(cache_write), 64'(0));
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_cache_addr", 64'(cache_addr), 64'(0));
        chk("rst_resp_rdata", 64'(resp_rdata), 64'(0));
        reset_n = 1'b1;
        @(negedge clock);
        chk("ready_after_reset", 64'(req_ready), 64'(1));

        // Directed sequence with zero-latency memory
        mem_lat = 0;
        run_txn(1'b1, 8'h10, 32'hDEAD_BEEF);
        run_txn(1'b0, 8'h10, '0);
        run_txn(1'b0, 8'h20, '0);
        run_txn(1'b0, 8'h20, '0);
        run_txn(1'b1, 8'h10, 32'hCAFE_F00D);
        run_txn(1'b1, 8'h20, 32'h0BAD_CAFE);
        run_txn(1'b1, 8'h30, 32'h3333_3333);
        chk("evict_one", 64'(int'(cache_has(8'h10)) + int'(cache_has(8'h20))), 64'(1));
        run_txn(1'b0, 8'h10, '0);
        run_txn(1'b0, 8'h30, '0);
        mem_lat = 3;
        run_txn(1'b1, 8'h30, 32'h3030_3030);
        run_txn(1'b0, 8'h50, '0);

        // Reset during MEM_RD
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h77;
        @(posedge clock);
        #1 req_valid = 1'b0; req_addr = '0;
        w = 0;
        while (!mem_req && (w < 20)) begin
            @(negedge clock);
            w++;
        end
        chk("abort_reached_memrd", 64'(mem_req), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("abort_mem_req", 64'(mem_req), 64'(0));
        chk("abort_req_ready", 64'(req_ready), 64'(0));
        chk("abort_cache_write", 64'(cache_write), 64'(0));
        w = 0;
        repeat (3) begin
            @(negedge clock);
            if (resp_valid) w++;
        end
        chk("abort_no_resp", 64'(w), 64'(0));
        reset_n = 1'b1;
        @(negedge clock);
        chk("abort_ready_after", 64'(req_ready), 64'(1));
        chk("abort_no_fill", 64'(cache_has(8'h77)), 64'(0));

        // Cache never answers: write must time out without touching memory
        force_miss = 1'b1;
        mem_lat = 0;
        do_req(1'b1, 8'h40, 32'h4444_4444, lat, rd, hit, err, n_mr, n_cw, first_mr, n_bad);
        chk("to_err", 64'(err), 64'(1));
        chk("to_hit", 64'(hit), 64'(0));
        chk("to_rdata", 64'(rd), 64'(0));
        chk("to_no_mem", 64'(n_mr), 64'(0));
        chk("to_lat", 64'(lat), 64'(WM + 2));
        chk("to_cwr_cycles", 64'(n_cw), 64'(WM));
        chk("to_mem_unchanged", 64'(mem_now(8'h40)), 64'(ref_mem[8'h40]));
        force_miss = 1'b0;

        // Randomized traffic over a small address set to force evictions
        for (int t = 0; t < 60; t++) begin
            mem_lat = ($urandom_range(0, 1) == 0) ? 0 : 3;
            run_txn(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 5)], $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected finished");
        $fatal(1, "watchdog");
    end

endmodule
